// File: rtl/axis_switch_simple_pkg.sv
// Shared types and constants for the simple 2x1 AXI-Stream merge switch.
package axis_switch_simple_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_S0   = 2'b01;
   localparam logic [1:0] GNT_S1   = 2'b10;

   // One-hot grant seen by the datapath for a given arbiter state.
   function automatic logic [1:0] grant_of(input state_t s);
      logic [1:0] g;
      case (s)
         ST_GNT0: g = GNT_S0;
         ST_GNT1: g = GNT_S1;
         default: g = GNT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/axis_switch_simple_rr_arb.sv
// Packet-level round-robin arbiter: picks an input in IDLE, holds it until the
// tlast beat is accepted, and remembers the winner for the next tie.
module axis_switch_simple_rr_arb
   import axis_switch_simple_pkg::*;
(
   input  logic       aclk,
   input  logic       areset,
   input  logic       req0,
   input  logic       req1,
   input  logic       beat_accepted,
   input  logic       beat_last,
   output logic [1:0] grant
);

   state_t state;
   state_t state_next;
   logic   last_grant;       // 0 = s0 won last, 1 = s1 won last
   logic   last_grant_next;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         grant      <= GNT_NONE;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         grant      <= grant_of(state_next);
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         ST_IDLE: begin
            if (req0 && req1) begin
               // tie goes to whichever input did not own the previous packet
               state_next = last_grant ? ST_GNT0 : ST_GNT1;
            end else if (req0) begin
               state_next = ST_GNT0;
            end else if (req1) begin
               state_next = ST_GNT1;
            end
         end
         ST_GNT0: begin
            if (beat_accepted && beat_last) begin
               state_next      = ST_IDLE;
               last_grant_next = 1'b0;
            end
         end
         ST_GNT1: begin
            if (beat_accepted && beat_last) begin
               state_next      = ST_IDLE;
               last_grant_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/axis_switch_simple_2x1.sv
// 2-input, 1-output AXI-Stream merge switch with packet round-robin arbitration
// and a single registered output stage.
module axis_switch_simple_2x1
   import axis_switch_simple_pkg::*;
#(
   parameter int unsigned DATAW = 24
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               s0_en,
   input  logic               s1_en,

   input  logic [DATAW-1:0]   s0_axis_tdata,
   input  logic               s0_axis_tvalid,
   output logic               s0_axis_tready,
   input  logic               s0_axis_tuser,
   input  logic               s0_axis_tlast,
   input  logic [DATAW/8-1:0] s0_axis_tstrb,
   input  logic [DATAW/8-1:0] s0_axis_tkeep,
   input  logic               s0_axis_tid,
   input  logic               s0_axis_tdest,

   input  logic [DATAW-1:0]   s1_axis_tdata,
   input  logic               s1_axis_tvalid,
   output logic               s1_axis_tready,
   input  logic               s1_axis_tuser,
   input  logic               s1_axis_tlast,
   input  logic [DATAW/8-1:0] s1_axis_tstrb,
   input  logic [DATAW/8-1:0] s1_axis_tkeep,
   input  logic               s1_axis_tid,
   input  logic               s1_axis_tdest,

   output logic [DATAW-1:0]   m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tuser,
   output logic               m_axis_tlast,
   output logic [DATAW/8-1:0] m_axis_tstrb,
   output logic [DATAW/8-1:0] m_axis_tkeep,
   output logic               m_axis_tid,
   output logic               m_axis_tdest,

   output logic [1:0]         grant
);

   localparam int unsigned KEEPW = DATAW / 8;

   logic             req0;
   logic             req1;
   logic             out_free;
   logic             acc0;
   logic             acc1;
   logic             beat_accepted;
   logic             beat_last;
   logic [DATAW-1:0] sel_tdata;
   logic             sel_tuser;
   logic [KEEPW-1:0] sel_tstrb;
   logic [KEEPW-1:0] sel_tkeep;
   logic             sel_tid;
   logic             sel_tdest;

   assign req0 = s0_en & s0_axis_tvalid;
   assign req1 = s1_en & s1_axis_tvalid;

   axis_switch_simple_rr_arb u_arb (
      .aclk          (aclk),
      .areset        (areset),
      .req0          (req0),
      .req1          (req1),
      .beat_accepted (beat_accepted),
      .beat_last     (beat_last),
      .grant         (grant)
   );

   // Output register can take a beat when empty or draining this cycle.
   always_comb begin
      out_free       = ~m_axis_tvalid | m_axis_tready;
      s0_axis_tready = ~areset & (grant == GNT_S0) & out_free;
      s1_axis_tready = ~areset & (grant == GNT_S1) & out_free;
      acc0           = s0_axis_tvalid & s0_axis_tready;
      acc1           = s1_axis_tvalid & s1_axis_tready;
      beat_accepted  = acc0 | acc1;
   end

   always_comb begin
      sel_tdata = s0_axis_tdata;
      sel_tuser = s0_axis_tuser;
      beat_last = s0_axis_tlast;
      sel_tstrb = s0_axis_tstrb;
      sel_tkeep = s0_axis_tkeep;
      sel_tid   = s0_axis_tid;
      sel_tdest = s0_axis_tdest;
      if (grant == GNT_S1) begin
         sel_tdata = s1_axis_tdata;
         sel_tuser = s1_axis_tuser;
         beat_last = s1_axis_tlast;
         sel_tstrb = s1_axis_tstrb;
         sel_tkeep = s1_axis_tkeep;
         sel_tid   = s1_axis_tid;
         sel_tdest = s1_axis_tdest;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tstrb  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tid    <= 1'b0;
         m_axis_tdest  <= 1'b0;
      end else if (beat_accepted) begin
         m_axis_tdata  <= sel_tdata;
         m_axis_tvalid <= 1'b1;
         m_axis_tuser  <= sel_tuser;
         m_axis_tlast  <= beat_last;
         m_axis_tstrb  <= sel_tstrb;
         m_axis_tkeep  <= sel_tkeep;
         m_axis_tid    <= sel_tid;
         m_axis_tdest  <= sel_tdest;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: doc/axis_switch_simple_2x1.md
Name: axis_switch_simple_2x1

Overview:
- 2-input, 1-output AXI-Stream merge switch; the return-path counterpart of the 1x2 simple switch.
- Packet-level round-robin arbitration between s0 and s1, gated by per-input enables.
- Grant is held from the first beat of a packet until its tlast beat.
- Single registered output stage. Used where two streams share one downstream consumer (DMA, FIFO, DSP chain).

Parameters:
- DATAW, 24, tdata width in bits; must be a multiple of 8. tstrb/tkeep width is DATAW/8.

Ports:
- aclk  in  1  clock for all logic
- areset  in  1  synchronous, active-high reset
- s0_en  in  1  input 0 eligible for arbitration
- s1_en  in  1  input 1 eligible for arbitration
- sN_axis_tdata  in  DATAW  (N=0,1) slave data
- sN_axis_tvalid  in  1  slave valid
- sN_axis_tready  out  1  slave ready
- sN_axis_tuser  in  1  slave user sideband
- sN_axis_tlast  in  1  slave end of packet
- sN_axis_tstrb  in  DATAW/8  slave byte strobe
- sN_axis_tkeep  in  DATAW/8  slave byte keep
- sN_axis_tid  in  1  slave stream id
- sN_axis_tdest  in  1  slave destination
- m_axis_tdata/tuser/tlast/tstrb/tkeep/tid/tdest  out  (same widths as slave)  registered master sideband
- m_axis_tvalid  out  1  master valid
- m_axis_tready  in  1  master ready
- grant  out  2  one-hot current grant (01 = s0, 10 = s1, 00 = idle)

Behaviour:
- Clocking and reset: one clock, aclk. Reset is synchronous and active-high on areset. Reset dominates all other inputs.
- Reset values: all m_axis_* = 0, s0/s1 tready = 0, grant = 00, state = IDLE, last_grant = s1 (so s0 wins the first tie).
- FSM states: IDLE, GNT0, GNT1.
- Requests: req0 = s0_en & s0_axis_tvalid; req1 = s1_en & s1_axis_tvalid.
- IDLE transitions:
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both → the input that is not last_grant.
  - Neither → stay in IDLE.
  - The arbitration decision takes 1 cycle. All treadys are 0 in IDLE.
- GNTx:
  - sx_axis_tready = ~m_axis_tvalid | m_axis_tready. The non-granted tready = 0.
  - Accepted beat (sx_tvalid & sx_tready): all sideband fields are registered into the output stage and m_axis_tvalid = 1 on the next cycle.
  - Accepted beat with tlast = 1: next state is IDLE and last_grant = x.
- Output stage:
  - When m_axis_tvalid = 1 and m_axis_tready = 0, all m_axis_* hold stable.
  - When m_axis_tready = 1 and no new beat is accepted, m_axis_tvalid clears to 0. Data may hold its old value.
- Latency and throughput:
  - First beat: s_tvalid seen in IDLE at cycle 0 → tready at cycle 1 → m_axis_tvalid at cycle 2.
  - Subsequent beats: 1-cycle latency at full throughput.
  - One idle cycle on s-side between packets, for re-arbitration.
- Enables: sampled only in IDLE. Deasserting sx_en mid-packet does not interrupt the granted packet.
- Sideband fields: tid, tdest and tuser pass through unmodified. No field rewriting.
- Single-beat packet (tlast on first beat): return to IDLE after one accepted beat.
- Reset mid-packet: immediate return to reset values. The partial packet is dropped downstream with no tlast; this is the system's responsibility.
- grant is a registered decode of state.

Decomposition:
- Package axis_switch_simple_pkg:
  - FSM state enum (IDLE, GNT0, GNT1).
  - Grant one-hot constants GNT_NONE / GNT_S0 / GNT_S1.
- Sub-module axis_switch_simple_rr_arb:
  - Holds the FSM and last_grant.
  - Inputs: req0, req1, beat_accepted, beat_last.
  - Outputs: grant. The top holds the data mux and output register.

Test Plan:
- Reset release with s0_en = s1_en = 1, both inputs offering 3-beat packets (A0..A2 on s0, B0..B2 on s1) → output order A0 A1 A2 B0 B1 B2; grant = 01 then 10; one bubble on the s-side between packets.
- Continuous 4-beat packets on both inputs for 4 packets → strict alternation s0, s1, s0, s1; every output tlast aligns with each packet's 4th beat; no beat lost or duplicated (scoreboard).
- s1_en = 0, s1 valid held high, s0 sends 2 packets → only s0 data is output; s1_axis_tready stays 0 throughout.
- m_axis_tready toggled 1010… during a 5-beat packet with tdata 0x000001..0x000005 → m_axis_* stable while stalled; all 5 values delivered in order; tkeep, tstrb, tuser, tid and tdest match the input per beat.
- s0_en dropped on beat 2 of a 4-beat packet → packet completes all 4 beats; s0 is not re-granted afterwards.
- areset pulsed for 1 cycle mid-packet while m_axis_tvalid = 1 → next cycle all outputs are 0 and grant = 00; a fresh tie is won by s0.
